// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by the fetch top, its buffer and the bench.
package fetch_pkg;

  localparam int XLEN    = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer between fetch and decode.
// Head entry drives the read data directly; clr empties it in one cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;
  assign rdata = mem_q[rd_q];

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    do_pop  = pop & !empty;
    do_push = push & (!full | do_pop);
    if (clr) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = wdata;
        wr_d        = inc(wr_q);
      end
      if (do_pop) rd_d = inc(rd_q);
      if (do_push & !do_pop) cnt_d = cnt_q + CW'(1);
      else if (!do_push & do_pop) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, one-outstanding imem handshake and
// in-order {pc, instr} delivery to decode with redirect flush.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                   DATAWIDTH  = 32,
  parameter logic [DATAWIDTH-1:0] RESET_PC   = '0,
  parameter int                   FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req,
  output logic [DATAWIDTH-1:0] imem_addr,
  input  logic                 imem_gnt,
  input  logic                 imem_rvalid,
  input  logic [31:0]          imem_rdata,
  input  logic                 redirect_valid,
  input  logic [DATAWIDTH-1:0] redirect_pc,
  output logic                 id_valid,
  input  logic                 id_ready,
  output logic [31:0]          id_instr,
  output logic [DATAWIDTH-1:0] id_pc
);

  localparam int EW = DATAWIDTH + 32;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e         state_q, state_d;
  logic [DATAWIDTH-1:0] pc_q, pc_d;
  logic                 req_q, req_d;
  logic                 gnt, push, pop, room;
  logic                 empty, full;
  logic [CW-1:0]        count;
  logic [EW-1:0]        head;
  logic [DATAWIDTH-1:0] rpc;

  assign gnt  = req_q & imem_gnt;
  assign pop  = !empty & id_ready;
  assign rpc  = redirect_pc & ~DATAWIDTH'(3);
  // A slot is still free after this push and any pop.
  assign room = (count < CW'(FIFO_DEPTH - 1)) | (pop & !full);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: if (!full) state_d = REQ;
      REQ:  if (gnt) state_d = WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          push    = 1'b1;
          pc_d    = pc_q + DATAWIDTH'(PC_STEP);
          state_d = room ? REQ : IDLE;
        end
      end
      DROP: if (imem_rvalid) state_d = REQ;
    endcase
    if (redirect_valid) begin
      push = 1'b0;
      pc_d = rpc;
      unique case (state_q)
        WAIT:    state_d = imem_rvalid ? REQ : DROP;
        REQ:     state_d = gnt ? DROP : REQ;
        DROP:    state_d = imem_rvalid ? REQ : DROP;
        default: state_d = REQ;
      endcase
    end
    req_d = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(EW)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (redirect_valid),
    .push (push),
    .pop  (pop),
    .wdata({pc_q, imem_rdata}),
    .rdata(head),
    .count(count),
    .empty(empty),
    .full (full)
  );

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign id_valid  = !empty;
  assign id_pc     = head[EW-1:32];
  assign id_instr  = head[31:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic,
// checked against a transaction-level fetch model.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] RPC = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  instr_fetch #(
    .DATAWIDTH (32),
    .RESET_PC  (RPC),
    .FIFO_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_instr      (id_instr),
    .id_pc         (id_pc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state
  fetch_entry_t exp_q[$];
  logic [31:0]  exp_pc;
  bit           pend;
  bit           pend_stale;
  logic [31:0]  pend_pc;
  logic [31:0]  mem_addr;
  int           resp_in;
  int           lat = 1;
  bit           lat_rand = 0;
  int           hs_n = 0;
  logic [31:0]  last_hs;
  logic [31:0]  hs_log[$];
  int           cyc = 0;
  int           first_hs = -1;
  int           first_v = -1;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_pc     = RPC;
    pend       = 0;
    pend_stale = 0;
    resp_in    = 0;
  endtask

  // One cycle: called at a negedge, drives inputs, advances the
  // model across the coming posedge, then checks at the next negedge.
  task automatic step(input bit gnt, input bit rdy, input bit redir,
                      input logic [31:0] rpc);
    bit rv;
    rv = pend && (resp_in == 1);
    imem_gnt       = gnt;
    id_ready       = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rvalid    = rv;
    imem_rdata     = rv ? memw(mem_addr) : $urandom;
    if (exp_q.size() != 0 && rdy && !redir) void'(exp_q.pop_front());
    if (rv) begin
      if (!pend_stale && !redir) begin
        exp_q.push_back('{pc: pend_pc, instr: memw(pend_pc)});
        exp_pc = pend_pc + 32'd4;
      end
      pend = 0;
    end else if (pend) begin
      resp_in--;
    end
    if (imem_req && gnt) begin
      chk("one_outstanding", 64'(pend), 64'd0);
      chk("fetch_addr", 64'(imem_addr), 64'(exp_pc));
      pend       = 1;
      pend_stale = 0;
      pend_pc    = exp_pc;
      mem_addr   = imem_addr;
      resp_in    = lat_rand ? int'($urandom_range(1, 3)) : lat;
      hs_n++;
      last_hs = imem_addr;
      hs_log.push_back(imem_addr);
      if (first_hs < 0) first_hs = cyc;
    end
    if (redir) begin
      exp_q.delete();
      exp_pc = {rpc[31:2], 2'b00};
      if (pend) pend_stale = 1;
    end
    @(negedge clk);
    cyc++;
    if (id_valid && first_v < 0) first_v = cyc;
    chk("no_overflow", 64'(exp_q.size() <= 2), 64'd1);
    chk("id_valid", 64'(id_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("id_pc", 64'(id_pc), 64'(exp_q[0].pc));
      chk("id_instr", 64'(id_instr), 64'(exp_q[0].instr));
    end
    chk("addr_align", 64'(imem_addr[1:0]), 64'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, 64'(imem_req), 64'd0);
    chk({tag, "_addr"}, 64'(imem_addr), 64'(RPC));
    chk({tag, "_valid"}, 64'(id_valid), 64'd0);
    chk({tag, "_instr"}, 64'(id_instr), 64'd0);
    chk({tag, "_pc"}, 64'(id_pc), 64'd0);
  endtask

  initial begin
    int h0;
    logic [31:0] a0;
    rst_n          = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;
    model_reset();
    #12;
    chk_reset_vals("rst");

    // Sequential fetch, 1-cycle memory, decode always ready
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_after_release", 64'(imem_req), 64'd1);
    for (int i = 0; i < 12; i++) step(1, 1, 0, '0);
    chk("seq_addr0", 64'(hs_log[0]), 64'h100);
    chk("seq_addr1", 64'(hs_log[1]), 64'h104);
    chk("seq_addr2", 64'(hs_log[2]), 64'h108);
    chk("latency", 64'(first_v - first_hs), 64'd2);
    chk("throughput", 64'(hs_n), 64'd6);

    // Reset asserted while a response is pending
    step(1, 1, 0, '0);
    chk("in_wait", 64'(pend), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("mid_rst");
    model_reset();
    imem_gnt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n       = 1'b1;
    id_ready    = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("stray_rvalid", 64'(id_valid), 64'd0);
    chk("stray_req", 64'(imem_req), 64'd1);

    // Backpressure
    h0 = hs_n;
    for (int i = 0; i < 12; i++) step(1, 0, 0, '0);
    chk("bp_fetches", 64'(hs_n - h0), 64'd2);
    chk("bp_req_low", 64'(imem_req), 64'd0);
    chk("bp_valid", 64'(id_valid), 64'd1);
    h0 = hs_n;
    for (int i = 0; i < 20 && hs_n == h0; i++) step(1, 1, 0, '0);
    chk("bp_resume_to", 64'(hs_n != h0), 64'd1);
    chk("bp_resume_addr", 64'(last_hs), 64'h108);
    for (int i = 0; i < 6; i++) step(1, 1, 0, '0);

    // Grant stall
    for (int i = 0; i < 10 && !imem_req; i++) step(0, 1, 0, '0);
    chk("stall_req_to", 64'(imem_req), 64'd1);
    a0 = imem_addr;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, '0);
      chk("stall_req", 64'(imem_req), 64'd1);
      chk("stall_addr", 64'(imem_addr), 64'(a0));
    end

    // Redirect while a response is pending
    lat = 3;
    h0  = hs_n;
    for (int i = 0; i < 20 && hs_n == h0; i++) step(1, 1, 0, '0);
    chk("rw_hs_to", 64'(hs_n != h0), 64'd1);
    step(0, 1, 1, 32'h203);
    chk("rw_valid", 64'(id_valid), 64'd0);
    h0 = hs_n;
    for (int i = 0; i < 20 && hs_n == h0; i++) step(1, 1, 0, '0);
    chk("rw_addr", 64'(last_hs), 64'h200);
    for (int i = 0; i < 20 && !id_valid; i++) step(1, 1, 0, '0);
    chk("rw_first_pc", 64'(id_pc), 64'h200);

    // Redirect together with a response and a pop
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() != 0 && pend && resp_in == 1) break;
      step(1, 0, 0, '0);
    end
    chk("rpp_setup", 64'(pend && resp_in == 1 && id_valid), 64'd1);
    step(1, 1, 1, 32'h300);
    chk("rpp_empty", 64'(id_valid), 64'd0);
    for (int i = 0; i < 20 && !id_valid; i++) step(1, 1, 0, '0);
    chk("rpp_first_pc", 64'(id_pc), 64'h300);

    // Random traffic
    lat_rand = 1;
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 19) == 0), $urandom);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the mySoC core. Holds the program counter, fetches 32-bit instructions from instruction memory over a request/grant/response handshake, and delivers `{pc, instr}` pairs in order to the decode stage, where the immediate generator consumes `instr`. Redirects from execute (taken branches and jumps) flush all queued and in-flight fetches.

## Interface
- `DATAWIDTH`, 32: PC and address width.
- `RESET_PC`, 32'h0000_0000: PC loaded at reset.
- `FIFO_DEPTH`, 2: decode-side buffer entries. Must be at least 2.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out DATAWIDTH: fetch address; bits [1:0] are always 0.
- `imem_gnt` in 1: request accepted in this cycle when `imem_req & imem_gnt`.
- `imem_rvalid` in 1: response data valid.
- `imem_rdata` in 32: instruction word.
- `redirect_valid` in 1: execute requests a PC change.
- `redirect_pc` in DATAWIDTH: new PC; bits [1:0] are ignored and forced to 0.
- `id_valid` out 1: the head entry is valid.
- `id_ready` in 1: decode accepts the head entry.
- `id_instr` out 32: instruction at the head entry.
- `id_pc` out DATAWIDTH: PC of the head entry.

## Operation
- **Memory contract**
  - At most one outstanding request.
  - A response arrives one or more cycles after the grant, never in the same cycle as the grant.
- **FSM states:** IDLE, REQ, WAIT, DROP.
  - **IDLE:** `imem_req`=0. Go to REQ when `count + 0 < FIFO_DEPTH`.
  - **REQ:** `imem_req`=1 and `imem_addr`=`pc`. Both are held stable until grant. On grant, go to WAIT.
  - **WAIT:** On `imem_rvalid`:
    - push `{pc, imem_rdata}`;
    - set `pc += 4`;
    - go to REQ if a slot remains after this push and any pop, else go to IDLE.
  - **DROP:** Discard the next `imem_rvalid` with no push and no PC change, then go to REQ.
- **Redirect** (highest priority, any state). In the same cycle:
  - `pc <= {redirect_pc[DATAWIDTH-1:2], 2'b00}`;
  - the FIFO is cleared and any pop in that cycle is void;
  - next state:
    - WAIT → DROP;
    - REQ with `imem_gnt`=1 → DROP;
    - WAIT with `imem_rvalid`=1 → REQ, and that response is discarded;
    - REQ without grant, IDLE, DROP → REQ. In DROP the pending response is still dropped, so the state stays DROP.
  - A redirect in REQ without grant may change `imem_addr` the next cycle; this is the only permitted address change while `imem_req` is high.
- **FIFO**
  - `id_valid` = !empty. The head drives `id_instr`/`id_pc` directly.
  - Pop on `id_valid & id_ready`.
  - Push and pop in the same cycle keep `count` unchanged.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- **Overflow:** never occurs, because a request is issued only when `count + pops < FIFO_DEPTH` (outstanding is 0 in REQ/IDLE).
- **PC arithmetic:** unsigned, wraps modulo 2^DATAWIDTH.

## Timing
- **Reset values**
  - `imem_req`=0.
  - `imem_addr`=`RESET_PC`.
  - `id_valid`=0.
  - `id_instr`=32'h0000_0000.
  - `id_pc`=0.
  - State=REQ, `pc`=`RESET_PC`.
- **After reset release**
  - `imem_req`=1 from the first rising edge after release.
  - Reset asserted mid-operation clears state immediately. A response arriving after release is ignored because the FSM is in REQ.
- **Latency:** grant in cycle N, `imem_rvalid` in N+1, `id_valid`=1 in N+2.
- **Throughput:** with 1-cycle memory, one instruction per 2 cycles (REQ, WAIT). No combinational path from `imem_rvalid` to `imem_req`.
- **Redirect timing:** redirect in cycle N gives `imem_addr`=`redirect_pc` with `imem_req`=1 in N+1 (or after the drop), and `id_valid`=0 in N+1.
- **Combinational paths:** `id_ready` has no combinational path to `imem_req`. All outputs are registered or come from FIFO storage.

## Structure
- **Package `fetch_pkg`**
  - `fetch_state_e` enum (IDLE, REQ, WAIT, DROP).
  - `fetch_entry_t` struct {pc, instr}.
  - Constant `PC_STEP`=4.
- **Sub-module `fetch_fifo`**
  - Parameterised depth/width, with a synchronous clear input for redirect.
  - Exposes count, empty and full.

## Test plan
- **Reset and sequential fetch:** release reset with `RESET_PC`=0x100, 1-cycle memory, `id_ready`=1 → `imem_addr` 0x100, 0x104, 0x108. `id_pc`/`id_instr` match memory in order; `id_valid` first high 2 cycles after the first grant.
- **Backpressure:** hold `id_ready`=0 → exactly 2 entries buffered, then `imem_req`=0. Raise `id_ready` → no loss and no duplication; fetching resumes at 0x108.
- **Grant stall:** `imem_gnt` low for 5 cycles → `imem_req` and `imem_addr` are held stable the whole time.
- **Redirect during WAIT:** redirect to 0x203 while a response is pending → the response is dropped, the next `imem_addr`=0x200, and the first delivered `id_pc`=0x200.
- **Redirect with push/pop:** redirect coincident with `imem_rvalid` and a decode pop → the FIFO is empty next cycle and the response is not delivered.
- **Reset mid-operation:** assert `rst_n`=0 during WAIT → outputs take their reset values asynchronously. A stray `imem_rvalid` after release produces no `id_valid`.
